// File: rtl/rsa256_mont_core.sv
// RSA modular exponentiation a^e mod n using right-to-left binary exponentiation
// over two parallel bit-serial Montgomery multipliers (no hardware multipliers).
module rsa256_mont_core #(
  parameter int W = 256
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         src_val,
  output logic         src_rdy,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_e,
  input  logic [W-1:0] i_n,
  output logic         result_val,
  input  logic         result_rdy,
  output logic [W-1:0] o_a_pow_e
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {IDLE, PREP, MONT, UPDATE, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  n_q, n_d, e_q, e_d, m_q, m_d, res_q, res_d;
  logic [W+1:0]  t_q, t_d, acc_p_q, acc_p_d, acc_s_q, acc_s_d;
  logic [CW-1:0] cnt_q, cnt_d, bit_q, bit_d;

  logic [W+1:0]  n_ext, t_dbl, add_p, add_s, sum_p, sum_s, red_s;
  logic [W-1:0]  red_p;
  logic          last_cnt, last_bit;

  assign n_ext    = {2'b00, n_q};
  assign t_dbl    = {t_q[W:0], 1'b0};
  assign last_cnt = (cnt_q == CW'(W - 1));
  assign last_bit = (bit_q == CW'(W - 1));

  // P multiplies m (plain) by t (Montgomery form), so m stays in plain form;
  // S squares t, keeping it in Montgomery form.
  assign add_p = acc_p_q + ({(W+2){m_q[cnt_q]}} & t_q);
  assign add_s = acc_s_q + ({(W+2){t_q[cnt_q]}} & t_q);
  assign sum_p = add_p + ({(W+2){add_p[0]}} & n_ext);
  assign sum_s = add_s + ({(W+2){add_s[0]}} & n_ext);
  assign red_p = W'((acc_p_q >= n_ext) ? acc_p_q - n_ext : acc_p_q);
  assign red_s = (acc_s_q >= n_ext) ? acc_s_q - n_ext : acc_s_q;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    e_d        = e_q;
    m_d        = m_q;
    res_d      = res_q;
    t_d        = t_q;
    acc_p_d    = acc_p_q;
    acc_s_d    = acc_s_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    src_rdy    = 1'b0;
    result_val = 1'b0;
    unique case (state_q)
      IDLE: begin
        src_rdy = 1'b1;
        if (src_val) begin
          n_d     = i_n;
          e_d     = i_e;
          t_d     = {2'b00, i_a};
          cnt_d   = '0;
          state_d = PREP;
        end
      end
      PREP: begin
        // W modular doublings bring a into Montgomery form a*2^W mod n.
        t_d   = (t_dbl >= n_ext) ? t_dbl - n_ext : t_dbl;
        cnt_d = cnt_q + 1'b1;
        if (last_cnt) begin
          m_d     = W'(1);
          cnt_d   = '0;
          bit_d   = '0;
          acc_p_d = '0;
          acc_s_d = '0;
          state_d = MONT;
        end
      end
      MONT: begin
        acc_p_d = sum_p >> 1;
        acc_s_d = sum_s >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (last_cnt) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        if (e_q[bit_q]) begin
          m_d = red_p;
        end
        t_d     = red_s;
        acc_p_d = '0;
        acc_s_d = '0;
        cnt_d   = '0;
        if (last_bit) begin
          res_d   = e_q[bit_q] ? red_p : m_q;
          state_d = DONE;
        end else begin
          bit_d   = bit_q + 1'b1;
          state_d = MONT;
        end
      end
      DONE: begin
        result_val = 1'b1;
        if (result_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      e_q     <= '0;
      m_q     <= '0;
      res_q   <= '0;
      t_q     <= '0;
      acc_p_q <= '0;
      acc_s_q <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      e_q     <= e_d;
      m_q     <= m_d;
      res_q   <= res_d;
      t_q     <= t_d;
      acc_p_q <= acc_p_d;
      acc_s_q <= acc_s_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  assign o_a_pow_e = res_q;

endmodule

// File: tb/tb_rsa256_mont_core.sv
// Directed bench for rsa256_mont_core: a W=16 instance for most behaviour and a
// W=64 instance for the full-width modulus cases.
module tb_rsa256_mont_core;
  localparam int WS    = 16;
  localparam int WL    = 64;
  localparam int LAT_S = WS + WS * (WS + 1);
  localparam int LAT_L = WL + WL * (WL + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          s_val_s = 1'b0, s_rdy_s, r_val_s, r_rdy_s = 1'b1;
  logic [WS-1:0] a_s = '0, e_s = '0, n_s = '0, res_s;
  logic          s_val_l = 1'b0, s_rdy_l, r_val_l, r_rdy_l = 1'b1;
  logic [WL-1:0] a_l = '0, e_l = '0, n_l = '0, res_l;

  int checks_cnt = 0;
  int errors_cnt = 0;

  rsa256_mont_core #(.W(WS)) u_dut_s (
    .i_clk(clk), .i_rst_n(rst_n),
    .src_val(s_val_s), .src_rdy(s_rdy_s),
    .i_a(a_s), .i_e(e_s), .i_n(n_s),
    .result_val(r_val_s), .result_rdy(r_rdy_s), .o_a_pow_e(res_s)
  );

  rsa256_mont_core #(.W(WL)) u_dut_l (
    .i_clk(clk), .i_rst_n(rst_n),
    .src_val(s_val_l), .src_rdy(s_rdy_l),
    .i_a(a_l), .i_e(e_l), .i_n(n_l),
    .result_val(r_val_l), .result_rdy(r_rdy_l), .o_a_pow_e(res_l)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Square-and-multiply reference with 128-bit intermediates.
  function automatic logic [63:0] mod_exp(input logic [63:0] a, input logic [63:0] e,
                                          input logic [63:0] n);
    logic [127:0] r, b, nn;
    nn = {64'd0, n};
    r  = 128'd1 % nn;
    b  = {64'd0, a} % nn;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[63:0];
  endfunction

  task automatic start_s(input logic [WS-1:0] a, input logic [WS-1:0] e,
                         input logic [WS-1:0] n, input string tag);
    int guard = 0;
    while (!s_rdy_s && guard < 1000) begin @(posedge clk); #1; guard++; end
    check_eq({tag, "_src_rdy"}, 64'(s_rdy_s), 64'd1);
    a_s = a; e_s = e; n_s = n; s_val_s = 1'b1;
    @(posedge clk); #1;
    s_val_s = 1'b0;
  endtask

  task automatic wait_result_s(input string tag, input logic [63:0] exp);
    int lat = 0;
    while (!r_val_s && lat < LAT_S + 50) begin @(posedge clk); #1; lat++; end
    check_eq({tag, "_lat"}, 64'(lat), 64'(LAT_S));
    check_eq({tag, "_res"}, 64'(res_s), exp);
    $display("txn %s result=%0h latency=%0d", tag, res_s, lat);
  endtask

  task automatic run_s(input logic [WS-1:0] a, input logic [WS-1:0] e,
                       input logic [WS-1:0] n, input logic [63:0] exp, input string tag);
    start_s(a, e, n, tag);
    wait_result_s(tag, exp);
    @(posedge clk); #1;
    check_eq({tag, "_val_drop"}, 64'(r_val_s), 64'd0);
    check_eq({tag, "_idle"}, 64'(s_rdy_s), 64'd1);
  endtask

  task automatic run_l(input logic [WL-1:0] a, input logic [WL-1:0] e,
                       input logic [WL-1:0] n, input logic [63:0] exp, input string tag);
    int   lat = 0;
    int   guard = 0;
    logic rdy_seen = 1'b0;
    while (!s_rdy_l && guard < 100) begin @(posedge clk); #1; guard++; end
    a_l = a; e_l = e; n_l = n; s_val_l = 1'b1;
    @(posedge clk); #1;
    s_val_l = 1'b0;
    while (!r_val_l && lat < LAT_L + 50) begin
      rdy_seen |= s_rdy_l;
      @(posedge clk); #1; lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(LAT_L));
    check_eq({tag, "_res"}, res_l, exp);
    check_eq({tag, "_rdy_low"}, 64'(rdy_seen), 64'd0);
    $display("txn %s result=%0h latency=%0d", tag, res_l, lat);
    @(posedge clk); #1;
    check_eq({tag, "_val_drop"}, 64'(r_val_l), 64'd0);
  endtask

  initial begin
    logic [WL-1:0] n_big;
    logic          bp_val_ok, bp_res_ok, bp_rdy_ok;

    #1;
    check_eq("rst_src_rdy", 64'(s_rdy_s), 64'd1);
    check_eq("rst_res_val", 64'(r_val_s), 64'd0);
    check_eq("rst_res", 64'(res_s), 64'd0);
    check_eq("rst_src_rdy_l", 64'(s_rdy_l), 64'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic and edge-case exponentiations
    run_s(16'd4, 16'd13, 16'd497, 64'd445, "basic");
    run_s(16'd3, 16'd0, 16'd7, 64'd1, "e_zero");
    run_s(16'd0, 16'd5, 16'd7, 64'd0, "a_zero");
    run_s(16'd2, 16'd10, 16'd1009, 64'd15, "pow2");

    // Full-width modulus on the wide instance (2^64 - 59 is prime)
    n_big = 64'hFFFF_FFFF_FFFF_FFC5;
    run_l(n_big - 64'd1, 64'd2, n_big, 64'd1, "full_neg1");
    run_l(64'd2, 64'hFFFF_FFFF_FFFF_FFFF, n_big,
          mod_exp(64'd2, 64'hFFFF_FFFF_FFFF_FFFF, n_big), "full_2pow");

    // Backpressure: result held for 100 cycles with a stray src_val pulse
    r_rdy_s = 1'b0;
    start_s(16'd2, 16'd10, 16'd1009, "bp");
    wait_result_s("bp", 64'd15);
    bp_val_ok = 1'b1; bp_res_ok = 1'b1; bp_rdy_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) begin
        a_s = 16'd3; e_s = 16'd3; n_s = 16'd11; s_val_s = 1'b1;
      end else begin
        s_val_s = 1'b0;
      end
      @(posedge clk); #1;
      bp_val_ok &= r_val_s;
      bp_res_ok &= (res_s == 16'd15);
      bp_rdy_ok &= ~s_rdy_s;
    end
    s_val_s = 1'b0;
    check_eq("bp_val_held", 64'(bp_val_ok), 64'd1);
    check_eq("bp_res_stable", 64'(bp_res_ok), 64'd1);
    check_eq("bp_src_rdy_low", 64'(bp_rdy_ok), 64'd1);
    r_rdy_s = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_val_drop", 64'(r_val_s), 64'd0);
    check_eq("bp_idle", 64'(s_rdy_s), 64'd1);

    // Asynchronous reset in the middle of MONT, then a normal run
    start_s(16'd4, 16'd13, 16'd497, "abort");
    repeat (WS + 100) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("abort_src_rdy", 64'(s_rdy_s), 64'd1);
    check_eq("abort_res_val", 64'(r_val_s), 64'd0);
    check_eq("abort_res", 64'(res_s), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_s(16'd4, 16'd13, 16'd497, 64'd445, "after_rst");

    // Back-to-back with src_val held high throughout
    start_s(16'd4, 16'd13, 16'd497, "b2b_1");
    s_val_s = 1'b1;
    wait_result_s("b2b_1", 64'd445);
    @(posedge clk); #1;
    check_eq("b2b_accept_idle", 64'(s_rdy_s), 64'd1);
    a_s = 16'd2; e_s = 16'd10; n_s = 16'd1009;
    @(posedge clk); #1;
    check_eq("b2b_second_hs", 64'(s_rdy_s), 64'd0);
    s_val_s = 1'b0;
    wait_result_s("b2b_2", 64'd15);
    @(posedge clk); #1;

    // Random vectors against the reference model
    for (int i = 0; i < 50; i++) begin
      logic [WS-1:0] rn, ra, re;
      rn = WS'($urandom) | WS'(1);
      if (rn == WS'(1)) rn = WS'(3);
      ra = WS'($urandom % 32'(rn));
      re = WS'($urandom);
      run_s(ra, re, rn, mod_exp(64'(ra), 64'(re), 64'(rn)), $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule
